// File: rtl/fb_write_arbiter_if.sv
// Pixel-write bundle shared by the clear engine, line engine, arbiter and framebuffer.
// No storage; pure signal grouping.
// Requesters see acks; the framebuffer side has no backpressure.
interface fb_write_arbiter_if;
  logic       frame_start;

  logic       c_req;
  logic [9:0] c_x;
  logic [8:0] c_y;
  logic       c_color;
  logic       c_last;
  logic       c_ack;

  logic       l_req;
  logic [9:0] l_x;
  logic [8:0] l_y;
  logic       l_color;
  logic       l_last;
  logic       l_ack;

  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_color;
  logic       pixel_write;
  logic       busy;
  logic [1:0] owner;
  logic       abort;

  modport slave (
    input  frame_start,
    input  c_req, c_x, c_y, c_color, c_last,
    input  l_req, l_x, l_y, l_color, l_last,
    output c_ack, l_ack,
    output x, y, pixel_color, pixel_write, busy, owner, abort
  );

  modport master (
    output frame_start,
    output c_req, c_x, c_y, c_color, c_last,
    output l_req, l_x, l_y, l_color, l_last,
    input  c_ack, l_ack,
    input  x, y, pixel_color, pixel_write, busy, owner, abort
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Burst-locked round-robin arbiter for the framebuffer pixel-write port (clear vs line engine).
// Latency: accepted pixel appears on x/y/pixel_color with pixel_write one cycle later.
// Backpressure: the non-owner's ack is held low; owner may stall (req low) until the timeout revokes it.
module fb_write_arbiter #(
  parameter bit SYNC_TO_FRAME = 1'b0,
  parameter int TIMEOUT       = 1024
) (
  input logic               clk,
  input logic               reset,
  fb_write_arbiter_if.slave bus
);

  // Counter only ever needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT of 0..2 still elaborates.
  localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, GRANT_C, GRANT_L} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sel_l;    // selection latched while waiting for frame_start (1 = L)
  logic          r_last_l;   // previous owner (1 = L); the other side wins a tie
  logic [CW-1:0] r_cnt;
  logic          r_abort;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic          r_color;
  logic          r_write;

  logic w_any;
  logic w_sel_l;
  logic w_granted;
  logic w_c_xfer;
  logic w_l_xfer;
  logic w_xfer;
  logic w_xlast;
  logic w_timeout;
  logic w_done;

  assign w_any     = bus.c_req | bus.l_req;
  assign w_sel_l   = bus.l_req & (~bus.c_req | ~r_last_l);
  assign w_granted = (r_state == GRANT_C) | (r_state == GRANT_L);
  assign w_c_xfer  = (r_state == GRANT_C) & bus.c_req;
  assign w_l_xfer  = (r_state == GRANT_L) & bus.l_req;
  assign w_xfer    = w_c_xfer | w_l_xfer;
  assign w_xlast   = (w_c_xfer & bus.c_last) | (w_l_xfer & bus.l_last);
  assign w_timeout = (TIMEOUT != 0) && w_granted && !w_xfer && (r_cnt == CNT_MAX);
  assign w_done    = w_xlast | w_timeout;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state plus acks/owner/busy decoded from the current state.
  always_comb begin
    w_next    = r_state;
    bus.c_ack = 1'b0;
    bus.l_ack = 1'b0;
    bus.owner = 2'b00;
    bus.busy  = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (SYNC_TO_FRAME) w_next = WAIT_FRAME;
          else               w_next = w_sel_l ? GRANT_L : GRANT_C;
        end
      end
      WAIT_FRAME: begin
        // Selection is committed; a dropped req here does not cancel it.
        if (bus.frame_start) w_next = r_sel_l ? GRANT_L : GRANT_C;
      end
      GRANT_C: begin
        bus.c_ack = bus.c_req;
        bus.owner = 2'b01;
        if (w_done) w_next = IDLE;
      end
      GRANT_L: begin
        bus.l_ack = bus.l_req;
        bus.owner = 2'b10;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Round-robin history, pending selection and the stall timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_l  <= 1'b0;
      r_last_l <= 1'b1;
      r_cnt    <= '0;
    end else begin
      if ((r_state == IDLE) && w_any) r_sel_l <= w_sel_l;
      if (w_done) r_last_l <= (r_state == GRANT_L);
      if (w_granted && !w_xfer && !w_timeout) r_cnt <= r_cnt + CW'(1);
      else                                    r_cnt <= '0;
    end
  end

  // One-cycle abort pulse coinciding with the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_abort <= 1'b0;
    else       r_abort <= w_timeout;
  end

  // Registered pixel towards the framebuffer; coordinates hold when no transfer occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_color <= 1'b0;
      r_write <= 1'b0;
    end else if (w_c_xfer) begin
      r_x     <= bus.c_x;
      r_y     <= bus.c_y;
      r_color <= bus.c_color;
      r_write <= 1'b1;
    end else if (w_l_xfer) begin
      r_x     <= bus.l_x;
      r_y     <= bus.l_y;
      r_color <= bus.l_color;
      r_write <= 1'b1;
    end else begin
      r_write <= 1'b0;
    end
  end

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.pixel_color = r_color;
  assign bus.pixel_write = r_write;
  assign bus.abort       = r_abort;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: scoreboard of expected framebuffer writes
// (value and cycle) plus directed state checks; one DUT with TIMEOUT=8, one frame-synchronised.
module tb_fb_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   s, r, b;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       col;
    int         cyc;
  } pix_t;

  pix_t qa[$];
  pix_t qb[$];
  pix_t ea, eb;

  fb_write_arbiter_if ia();
  fb_write_arbiter_if ib();

  fb_write_arbiter #(.SYNC_TO_FRAME(1'b0), .TIMEOUT(8)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  fb_write_arbiter #(.SYNC_TO_FRAME(1'b1), .TIMEOUT(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic at_neg(input int c);
    go(c);
    @(negedge clk);
  endtask

  task automatic push_a(input logic [9:0] x, input logic [8:0] y, input logic col, input int c);
    pix_t p;
    p.x = x; p.y = y; p.col = col; p.cyc = c;
    qa.push_back(p);
  endtask

  task automatic push_b(input logic [9:0] x, input logic [8:0] y, input logic col, input int c);
    pix_t p;
    p.x = x; p.y = y; p.col = col; p.cyc = c;
    qb.push_back(p);
  endtask

  task automatic drive_idle();
    ia.frame_start = 0; ib.frame_start = 0;
    ia.c_req = 0; ia.c_x = 0; ia.c_y = 0; ia.c_color = 0; ia.c_last = 0;
    ia.l_req = 0; ia.l_x = 0; ia.l_y = 0; ia.l_color = 0; ia.l_last = 0;
    ib.c_req = 0; ib.c_x = 0; ib.c_y = 0; ib.c_color = 0; ib.c_last = 0;
    ib.l_req = 0; ib.l_x = 0; ib.l_y = 0; ib.l_color = 0; ib.l_last = 0;
  endtask

  // Requester model on DUT A: presents each pixel until it is acked (bounded wait).
  task automatic send(input bit is_l, input int n, input logic [9:0] x0, input logic [8:0] y0,
                      input int dx, input int dy, input logic col, input bit last_flag);
    logic       got;
    int         k;
    logic [9:0] px;
    logic [8:0] py;
    for (int i = 0; i < n; i++) begin
      px = 10'(int'(x0) + dx * i);
      py = 9'(int'(y0) + dy * i);
      if (is_l) begin
        ia.l_req = 1; ia.l_x = px; ia.l_y = py; ia.l_color = col; ia.l_last = last_flag && (i == n - 1);
      end else begin
        ia.c_req = 1; ia.c_x = px; ia.c_y = py; ia.c_color = col; ia.c_last = last_flag && (i == n - 1);
      end
      got = 0;
      k   = 0;
      while (!got && k < 100) begin
        @(negedge clk);
        got = is_l ? ia.l_ack : ia.c_ack;
        tick();
        k++;
      end
      if (is_l) chk("L ack arrives", {31'b0, got}, 32'd1);
      else      chk("C ack arrives", {31'b0, got}, 32'd1);
    end
    if (is_l) begin ia.l_req = 0; ia.l_last = 0; end
    else      begin ia.c_req = 0; ia.c_last = 0; end
  endtask

  // Scoreboard monitor for DUT A writes.
  always @(negedge clk) begin
    if (reset === 1'b0 && ia.pixel_write === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++;
        $display("FAIL A unexpected write: got write x=%0d y=%0d at cycle %0d, expected none", ia.x, ia.y, cyc);
      end else begin
        ea = qa.pop_front();
        chk("A pixel x", ia.x, ea.x);
        chk("A pixel y", ia.y, ea.y);
        chk("A pixel color", ia.pixel_color, ea.col);
        chk("A write cycle", cyc, ea.cyc);
      end
    end
  end

  // Scoreboard monitor for DUT B writes.
  always @(negedge clk) begin
    if (reset === 1'b0 && ib.pixel_write === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++;
        $display("FAIL B unexpected write: got write x=%0d y=%0d at cycle %0d, expected none", ib.x, ib.y, cyc);
      end else begin
        eb = qb.pop_front();
        chk("B pixel x", ib.x, eb.x);
        chk("B pixel y", ib.y, eb.y);
        chk("B pixel color", ib.pixel_color, eb.col);
        chk("B write cycle", cyc, eb.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    drive_idle();
    ia.c_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset pixel_write", ia.pixel_write, 0);
    chk("reset x", ia.x, 0);
    chk("reset y", ia.y, 0);
    chk("reset color", ia.pixel_color, 0);
    chk("reset busy", ia.busy, 0);
    chk("reset owner", ia.owner, 0);
    chk("reset abort", ia.abort, 0);
    chk("reset c_ack with c_req high", ia.c_ack, 0);
    chk("reset B busy", ib.busy, 0);
    ia.c_req = 0;
    tick();
    reset = 0;
    tick();
    tick();

    // Simultaneous requests: C wins the first tie, one idle cycle, then L.
    s = cyc;
    push_a(10'd0, 9'd0, 1'b0, s + 2);
    push_a(10'd1, 9'd0, 1'b0, s + 3);
    push_a(10'd2, 9'd0, 1'b0, s + 4);
    push_a(10'd5, 9'd100, 1'b1, s + 6);
    push_a(10'd5, 9'd101, 1'b1, s + 7);
    push_a(10'd5, 9'd102, 1'b1, s + 8);
    fork
      send(1'b0, 3, 10'd0, 9'd0, 1, 0, 1'b0, 1'b1);
      send(1'b1, 3, 10'd5, 9'd100, 0, 1, 1'b1, 1'b1);
    join
    repeat (3) tick();

    // Burst lock: L raised during C's 5-pixel burst waits for C to finish.
    s = cyc;
    for (int i = 0; i < 5; i++) push_a(10'(10 + i), 9'd20, 1'b0, s + 2 + i);
    push_a(10'd50, 9'd60, 1'b1, s + 8);
    fork
      send(1'b0, 5, 10'd10, 9'd20, 1, 0, 1'b0, 1'b1);
      begin
        go(s + 2);
        send(1'b1, 1, 10'd50, 9'd60, 0, 0, 1'b1, 1'b1);
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          at_neg(s + k);
          chk("lock owner C", ia.owner, 2'b01);
          chk("lock l_ack low", ia.l_ack, 0);
        end
        at_neg(s + 6);
        chk("rearb l_ack low", ia.l_ack, 0);
        chk("rearb owner none", ia.owner, 2'b00);
        at_neg(s + 7);
        chk("L granted l_ack", ia.l_ack, 1);
        chk("L granted owner", ia.owner, 2'b10);
      end
    join
    repeat (3) tick();

    // Timeout: L sends one non-last pixel then stalls; C pending behind it.
    s = cyc;
    push_a(10'd100, 9'd200, 1'b1, s + 2);
    push_a(10'd300, 9'd400, 1'b0, s + 12);
    fork
      send(1'b1, 1, 10'd100, 9'd200, 0, 0, 1'b1, 1'b0);
      begin
        go(s + 4);
        send(1'b0, 1, 10'd300, 9'd400, 0, 0, 1'b0, 1'b1);
      end
      begin
        at_neg(s + 9);
        chk("stall owner L", ia.owner, 2'b10);
        chk("stall abort low", ia.abort, 0);
        chk("stall busy", ia.busy, 1);
        at_neg(s + 10);
        chk("timeout abort", ia.abort, 1);
        chk("timeout owner", ia.owner, 2'b00);
        chk("timeout busy", ia.busy, 0);
        chk("timeout c_ack", ia.c_ack, 0);
        at_neg(s + 11);
        chk("abort one cycle", ia.abort, 0);
        chk("C after timeout owner", ia.owner, 2'b01);
        chk("C after timeout c_ack", ia.c_ack, 1);
      end
    join
    repeat (3) tick();

    // Reset at the 3rd pixel of an L burst; last owner was C, yet C wins after reset.
    s = cyc;
    push_a(10'd300, 9'd10, 1'b1, s + 2);
    ia.l_req = 1; ia.l_x = 10'd300; ia.l_y = 9'd10; ia.l_color = 1; ia.l_last = 0;
    tick();
    tick();
    ia.l_x = 10'd301;
    tick();
    ia.l_x = 10'd302;
    #1;
    reset = 1;
    @(negedge clk);
    chk("midreset l_ack", ia.l_ack, 0);
    chk("midreset pixel_write", ia.pixel_write, 0);
    chk("midreset busy", ia.busy, 0);
    chk("midreset owner", ia.owner, 0);
    chk("midreset x", ia.x, 0);
    tick();
    tick();
    ia.l_req = 0;
    reset = 0;
    r = cyc;
    push_a(10'd1, 9'd2, 1'b0, r + 2);
    push_a(10'd3, 9'd4, 1'b1, r + 4);
    fork
      send(1'b0, 1, 10'd1, 9'd2, 0, 0, 1'b0, 1'b1);
      send(1'b1, 1, 10'd3, 9'd4, 0, 0, 1'b1, 1'b1);
    join
    repeat (3) tick();

    // Single requester C, two back-to-back bursts with a one-cycle gap.
    s = cyc;
    for (int i = 0; i < 3; i++) push_a(10'(i), 9'd5, 1'b1, s + 2 + i);
    for (int i = 0; i < 2; i++) push_a(10'(20 + i), 9'd6, 1'b0, s + 6 + i);
    send(1'b0, 3, 10'd0, 9'd5, 1, 0, 1'b1, 1'b1);
    send(1'b0, 2, 10'd20, 9'd6, 1, 0, 1'b0, 1'b1);
    repeat (3) tick();

    // Frame-synchronised DUT: grant waits for a frame_start after selection.
    b = cyc;
    push_b(10'd9, 9'd8, 1'b1, b + 42);
    go(b + 10);
    ib.l_req = 1; ib.l_x = 10'd9; ib.l_y = 9'd8; ib.l_color = 1; ib.l_last = 1;
    ib.frame_start = 1;
    @(negedge clk);
    chk("sync idle busy", ib.busy, 0);
    go(b + 11);
    ib.frame_start = 0;
    @(negedge clk);
    chk("sync wait busy", ib.busy, 1);
    chk("sync wait owner", ib.owner, 2'b00);
    chk("sync wait l_ack", ib.l_ack, 0);
    go(b + 20);
    ib.l_req = 0;
    at_neg(b + 25);
    chk("sync req drop keeps busy", ib.busy, 1);
    go(b + 30);
    ib.l_req = 1;
    go(b + 40);
    ib.frame_start = 1;
    @(negedge clk);
    chk("sync frame cycle owner", ib.owner, 2'b00);
    chk("sync frame cycle l_ack", ib.l_ack, 0);
    go(b + 41);
    ib.frame_start = 0;
    @(negedge clk);
    chk("sync granted l_ack", ib.l_ack, 1);
    chk("sync granted owner", ib.owner, 2'b10);
    go(b + 42);
    ib.l_req = 0; ib.l_last = 0;
    @(negedge clk);
    chk("sync done busy", ib.busy, 0);
    repeat (4) tick();

    chk("A scoreboard drained", qa.size(), 0);
    chk("B scoreboard drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
